// File: rtl/reset_seq_pkg.sv
// Shared types and limits for the staged reset-release controller.
package reset_seq_pkg;

  localparam int MAX_STAGES = 16;

  typedef enum logic [2:0] {
    SYNC,
    GAP,
    WAIT_ACK,
    RUN,
    DRAIN
  } rseq_state_t;

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert, sync-deassert reset synchronizer: a chain of async-cleared flops
// with D tied high, so release only ever propagates through WIDTH clock edges.
module rst_sync_chain #(
  parameter int WIDTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);

  logic [WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[WIDTH-2:0], 1'b1};
    end
  end

  assign sync_o = chain_q[WIDTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order with a gap and optional
// per-stage ack; a warm reset re-asserts them in reverse and replays the release.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int AW    = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [GW-1:0]    GAP_INIT     = GW'(GAP_CYCLES);
  localparam logic [AW-1:0]    ACK_LAST     = AW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] DRAIN_START  = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);
  localparam logic             NO_HANDSHAKE = (ACK_TIMEOUT == 0);

  rseq_state_t           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [GW-1:0]         gapCnt_q;
  logic [AW-1:0]         ackCnt_q;
  logic [NUM_STAGES-1:0] stageRstN_q;
  logic                  seqDone_q;
  logic                  timeoutErr_q;
  logic                  busy_q;

  logic syncRelease;
  logic ackOk;
  logic ackExpired;
  logic lastStage;

  rst_sync_chain #(
    .WIDTH (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .sync_o (syncRelease)
  );

  assign ackOk      = stage_ack[idx_q] | NO_HANDSHAKE;
  assign ackExpired = (ackCnt_q == ACK_LAST);
  assign lastStage  = (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SYNC;
      idx_q        <= '0;
      gapCnt_q     <= '0;
      ackCnt_q     <= '0;
      stageRstN_q  <= '0;
      seqDone_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        SYNC: begin
          if (syncRelease) begin
            gapCnt_q <= GAP_INIT;
            state_q  <= GAP;
          end
        end

        GAP: begin
          gapCnt_q <= gapCnt_q - 1'b1;
          if (gapCnt_q == GW'(1)) begin
            stageRstN_q[idx_q] <= 1'b1;
            ackCnt_q           <= '0;
            state_q            <= WAIT_ACK;
          end
        end

        // An ack arriving on the expiry edge wins; no error is flagged for it.
        WAIT_ACK: begin
          if (ackOk || ackExpired) begin
            if (!ackOk) begin
              timeoutErr_q <= 1'b1;
            end
            if (lastStage) begin
              seqDone_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= RUN;
            end else begin
              idx_q    <= idx_q + 1'b1;
              gapCnt_q <= GAP_INIT;
              state_q  <= GAP;
            end
          end else begin
            ackCnt_q <= ackCnt_q + 1'b1;
          end
        end

        RUN: begin
          if (sw_rst_req) begin
            seqDone_q                   <= 1'b0;
            timeoutErr_q                <= 1'b0;
            busy_q                      <= 1'b1;
            stageRstN_q[NUM_STAGES-1]   <= 1'b0;
            if (NUM_STAGES == 1) begin
              idx_q    <= '0;
              gapCnt_q <= GAP_INIT;
              state_q  <= GAP;
            end else begin
              idx_q   <= DRAIN_START;
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          stageRstN_q[idx_q] <= 1'b0;
          if (idx_q == '0) begin
            gapCnt_q <= GAP_INIT;
            state_q  <= GAP;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end

        default: begin
          state_q <= SYNC;
        end
      endcase
    end
  end

  assign stage_rst_n = stageRstN_q;
  assign seq_done    = seqDone_q;
  assign timeout_err = timeoutErr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (4 stages, 2-flop sync, gap 8, ack timeout 4);
// expected release edges are hand-derived from the edge numbering after rst release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] stage_ack = 4'b0000;
  logic [3:0] stage_rst_n;
  logic       seq_done;
  logic       timeout_err;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  reset_sequencer #(
    .NUM_STAGES  (4),
    .SYNC_STAGES (2),
    .GAP_CYCLES  (8),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Holds rst low for two cycles and releases it between edges, so the next
  // rising edge is edge 1 of the release sequence.
  task automatic applyStimulus();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (stage_rst_n !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_stage: got %b want 0000", stage_rst_n);
    end
    compared++;
    if (seq_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_done: got %b want 0", seq_done);
    end
    compared++;
    if (timeout_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_err: got %b want 0", timeout_err);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %b want 1", busy);
    end
  endtask

  // Acks tied high: stage k released at edge 11+9k, seq_done at 39.
  task automatic test_default_sequence();
    logic [6:0] got, exp;
    stage_ack = 4'b1111;
    applyStimulus();
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      exp = '0;
      for (int k = 0; k < 4; k++) if (e >= 11 + 9 * k) exp[3+k] = 1'b1;
      exp[2] = (e >= 39);
      exp[1] = 1'b0;
      exp[0] = (e < 39);
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL default_seq edge %0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  // Stage 1 never acks: WAIT_ACK runs edges 21..24, error at 24, stage 2 at 32.
  task automatic test_timeout();
    logic [6:0] got, exp;
    int rel [4] = '{11, 20, 32, 41};
    stage_ack = 4'b1101;
    applyStimulus();
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      exp = '0;
      for (int k = 0; k < 4; k++) if (e >= rel[k]) exp[3+k] = 1'b1;
      exp[2] = (e >= 42);
      exp[1] = (e >= 24);
      exp[0] = (e < 42);
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL timeout_seq edge %0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  // Runs from RUN with timeout_err set; pulse sampled at edge E (j=0).
  task automatic test_warm_reset();
    logic [6:0] got, exp;
    stage_ack  = 4'b1111;
    sw_rst_req = 1'b1;
    for (int j = 0; j <= 41; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) sw_rst_req = 1'b0;
      exp = '0;
      if (j < 3) begin
        exp[6:3] = 4'b1111 >> (j + 1);
      end else begin
        for (int k = 0; k < 4; k++) if (j >= 11 + 9 * k) exp[3+k] = 1'b1;
      end
      exp[2] = (j >= 39);
      exp[1] = 1'b0;
      exp[0] = (j < 39);
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL warm_reset E+%0d: got %b want %b", j, got, exp);
      end
    end
  endtask

  task automatic test_async_mid_gap();
    logic [6:0] got, exp;
    stage_ack = 4'b1111;
    applyStimulus();
    repeat (25) @(posedge clk);
    #1;
    compared++;
    if (stage_rst_n !== 4'b0011) begin
      mismatched++;
      $display("[TB] FAIL async_pre: got %b want 0011", stage_rst_n);
    end
    #2;
    rst = 1'b0;
    #1;
    got = {stage_rst_n, seq_done, timeout_err, busy};
    compared++;
    if (got !== 7'b0000_001) begin
      mismatched++;
      $display("[TB] FAIL async_clear: got %b want 0000001", got);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      exp = '0;
      for (int k = 0; k < 4; k++) if (e >= 11 + 9 * k) exp[3+k] = 1'b1;
      exp[2] = (e >= 39);
      exp[0] = (e < 39);
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL async_replay edge %0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  // Request held from reset: ignored until RUN (entered at 39), drains from edge 40.
  task automatic test_sw_req_held();
    logic [6:0] got, exp;
    int j;
    stage_ack  = 4'b1111;
    sw_rst_req = 1'b1;
    applyStimulus();
    for (int e = 1; e <= 85; e++) begin
      @(posedge clk);
      #1;
      if (e == 40) sw_rst_req = 1'b0;
      exp = '0;
      if (e <= 39) begin
        for (int k = 0; k < 4; k++) if (e >= 11 + 9 * k) exp[3+k] = 1'b1;
        exp[2] = (e >= 39);
        exp[0] = (e < 39);
      end else begin
        j = e - 40;
        if (j < 3) begin
          exp[6:3] = 4'b1111 >> (j + 1);
        end else begin
          for (int k = 0; k < 4; k++) if (j >= 11 + 9 * k) exp[3+k] = 1'b1;
        end
        exp[2] = (j >= 39);
        exp[0] = (j < 39);
      end
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL sw_held edge %0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  // Ack for stage 1 arrives on the expiry edge (24): treated as ack, no error.
  task automatic test_ack_on_timeout_edge();
    logic [6:0] got, exp;
    int rel [4] = '{11, 20, 32, 41};
    stage_ack = 4'b1101;
    applyStimulus();
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (e == 23) stage_ack = 4'b1111;
      exp = '0;
      for (int k = 0; k < 4; k++) if (e >= rel[k]) exp[3+k] = 1'b1;
      exp[2] = (e >= 42);
      exp[1] = 1'b0;
      exp[0] = (e < 42);
      got = {stage_rst_n, seq_done, timeout_err, busy};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL ack_same_edge edge %0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  initial begin
    $display("[TB] reset_sequencer directed tests");
    test_reset();
    test_default_sequence();
    test_timeout();
    test_warm_reset();
    test_async_mid_gap();
    test_sw_req_held();
    test_ack_on_timeout_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
